// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the transmit launch FSM encoding.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side and uart_tx-side signal bundle of uart_tx_fifo.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic                   wr_valid_i;
  logic [UART_DATA_W-1:0] wr_data_i;
  logic                   wr_ready_o;
  logic                   tx_e_o;
  logic [UART_DATA_W-1:0] tx_d_o;
  logic                   tx_busy_i;
  logic                   tx_done_i;
  logic [ADDR_W:0]        count_o;
  logic                   empty_o;
  logic                   full_o;
  logic                   overflow_o;
  logic                   clr_ovf_i;

  // master drives the FIFO inputs (producer plus uart_tx status); slave is the FIFO
  modport master (
    output wr_valid_i, wr_data_i, tx_busy_i, tx_done_i, clr_ovf_i,
    input  wr_ready_o, tx_e_o, tx_d_o, count_o, empty_o, full_o, overflow_o
  );

  modport slave (
    input  wr_valid_i, wr_data_i, tx_busy_i, tx_done_i, clr_ovf_i,
    output wr_ready_o, tx_e_o, tx_d_o, count_o, empty_o, full_o, overflow_o
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Generic DEPTH x WIDTH circular buffer; head entry is readable without a pop.
module uart_sync_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int WIDTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [ADDR_W:0]  count,
  output logic             full,
  output logic             empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointer wrap is plain binary overflow
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of uart_tx: buffers producer bytes and launches them one frame at a time.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           resetn,
  uart_tx_fifo_if.slave  bus
);

  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [UART_DATA_W-1:0] head;
  logic [ADDR_W:0]        count;
  tx_state_e              state;
  logic                   tx_e;
  logic [UART_DATA_W-1:0] tx_d;
  logic                   ovf;

  // Readiness uses the pre-edge full flag, so a same-edge pop never frees a slot early
  assign push = bus.wr_valid_i && !full;
  assign pop  = (state == IDLE) && !empty && !bus.tx_busy_i;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (bus.wr_data_i),
    .pop       (pop),
    .pop_data  (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      tx_e  <= 1'b0;
      tx_d  <= '0;
    end else begin
      tx_e <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          tx_d  <= head;
          tx_e  <= 1'b1;
          state <= SEND;
        end
        SEND:    state <= WAIT;
        WAIT:    if (bus.tx_done_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A rejected write outranks a clear arriving on the same edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                         ovf <= 1'b0;
    else if (bus.wr_valid_i && full)     ovf <= 1'b1;
    else if (bus.clr_ovf_i)              ovf <= 1'b0;
  end

  assign bus.wr_ready_o = !full;
  assign bus.tx_e_o     = tx_e;
  assign bus.tx_d_o     = tx_d;
  assign bus.count_o    = count;
  assign bus.empty_o    = empty;
  assign bus.full_o     = full;
  assign bus.overflow_o = ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, corner-case sequences and a random stream vs a queue model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();
  uart_tx_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int checks = 0;
  int errors = 0;

  byte unsigned mq[$];
  byte unsigned out_log[$];
  byte unsigned in_log[$];
  bit  m_ovf;
  bit  auto_tx;
  int  tx_timer;
  int  tx_len_max = 4;
  byte unsigned cur_d;
  bit  prev_e;

  typedef struct {
    bit  v;
    byte unsigned d;
    bit  busy;
    bit  done;
    bit  clr;
    bit  e;
    byte unsigned q;
    int  cnt;
    bit  ovf;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_wr(bit v, byte unsigned d, bit clr);
    bus.wr_valid_i = v;
    bus.wr_data_i  = d;
    bus.clr_ovf_i  = clr;
  endtask

  // One clock: predict from the pre-edge model, then compare after the edge
  task automatic tick();
    int pre_n;
    bit acc;
    bit inflight;
    byte unsigned d_pre;
    byte unsigned exp_d;
    pre_n = mq.size();
    d_pre = bus.wr_data_i;
    acc = bus.wr_valid_i && (pre_n < DEPTH);
    if (bus.wr_valid_i && pre_n == DEPTH) m_ovf = 1'b1;
    else if (bus.clr_ovf_i)               m_ovf = 1'b0;
    inflight = auto_tx && (tx_timer > 0 || bus.tx_done_i);
    @(posedge clk);
    #1;
    if (bus.tx_e_o) begin
      chk("pulse_width", int'(prev_e), 0);
      chk("launch_nonempty", int'(pre_n > 0), 1);
      chk("launch_while_busy", int'(inflight), 0);
      if (pre_n > 0) begin
        exp_d = mq.pop_front();
        chk("tx_d_order", bus.tx_d_o, exp_d);
      end
      out_log.push_back(bus.tx_d_o);
      cur_d = bus.tx_d_o;
    end
    if (acc) mq.push_back(d_pre);
    prev_e = bus.tx_e_o;
    chk("count", bus.count_o, mq.size());
    chk("empty", bus.empty_o, int'(mq.size() == 0));
    chk("full", bus.full_o, int'(mq.size() == DEPTH));
    chk("ready", bus.wr_ready_o, int'(mq.size() != DEPTH));
    chk("overflow", bus.overflow_o, m_ovf);
    if (auto_tx) begin
      bus.tx_done_i = 1'b0;
      if (bus.tx_e_o) begin
        bus.tx_busy_i = 1'b1;
        tx_timer = $urandom_range(tx_len_max, 1);
      end else if (tx_timer > 0) begin
        chk("tx_d_hold", bus.tx_d_o, cur_d);
        tx_timer--;
        if (tx_timer == 0) begin
          bus.tx_done_i = 1'b1;
          bus.tx_busy_i = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    set_wr(1'b0, 8'h00, 1'b0);
    bus.tx_busy_i = 1'b0;
    bus.tx_done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    tx_timer = 0;
    prev_e = 1'b0;
  endtask

  task automatic drain(int budget);
    int n = 0;
    set_wr(1'b0, 8'h00, 1'b0);
    while ((mq.size() != 0 || tx_timer != 0 || bus.tx_done_i || bus.tx_e_o) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", int'(n < budget), 1);
    tick();
    tick();
  endtask

  // Hand the launch that just happened in manual mode over to the uart_tx model
  task automatic go_auto();
    auto_tx = 1'b1;
    bus.tx_busy_i = 1'b1;
    tx_timer = 2;
    cur_d = bus.tx_d_o;
  endtask

  initial begin
    int accepted;
    int n;
    int maxc;
    int ff_seen;
    bit v;
    byte unsigned d;

    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 0, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 0, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 0, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 0, 1'b0};
    tbl[5]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 0, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 0, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 1'b0};
    tbl[10] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 0, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 0, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 0, 1'b0};

    auto_tx = 1'b0;
    do_reset();
    chk("rst_ready", bus.wr_ready_o, 1);
    chk("rst_empty", bus.empty_o, 1);
    chk("rst_count", bus.count_o, 0);
    chk("rst_tx_e", bus.tx_e_o, 0);
    chk("rst_tx_d", bus.tx_d_o, 8'h00);
    chk("rst_ovf", bus.overflow_o, 0);

    // Single byte latency, done ignored in SEND, busy holding IDLE
    for (int i = 0; i < 15; i++) begin
      set_wr(tbl[i].v, tbl[i].d, tbl[i].clr);
      bus.tx_busy_i = tbl[i].busy;
      bus.tx_done_i = tbl[i].done;
      tick();
      chk($sformatf("tbl%0d_tx_e", i), bus.tx_e_o, tbl[i].e);
      chk($sformatf("tbl%0d_tx_d", i), bus.tx_d_o, tbl[i].q);
      chk($sformatf("tbl%0d_count", i), bus.count_o, tbl[i].cnt);
      chk($sformatf("tbl%0d_ovf", i), bus.overflow_o, tbl[i].ovf);
    end
    bus.tx_done_i = 1'b0;

    // Burst to full with uart_tx busy, then overflow and its clear
    bus.tx_busy_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_wr(1'b1, 8'(i), 1'b0);
      tick();
    end
    chk("burst_full", bus.full_o, 1);
    chk("burst_ready", bus.wr_ready_o, 0);
    set_wr(1'b1, 8'hFF, 1'b0);
    tick();
    chk("burst_ovf_set", bus.overflow_o, 1);
    chk("burst_count", bus.count_o, DEPTH);
    set_wr(1'b0, 8'h00, 1'b1);
    tick();
    chk("ovf_clear", bus.overflow_o, 0);
    set_wr(1'b1, 8'hEE, 1'b1);
    tick();
    chk("ovf_set_wins", bus.overflow_o, 1);
    set_wr(1'b0, 8'h00, 1'b1);
    tick();
    chk("ovf_clear2", bus.overflow_o, 0);
    out_log.delete();
    auto_tx = 1'b1;
    bus.tx_busy_i = 1'b0;
    drain(2000);
    chk("burst_out_len", out_log.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < out_log.size(); i++)
      chk($sformatf("burst_out%0d", i), out_log[i], i);

    // Simultaneous push and launch at count 5
    auto_tx = 1'b0;
    bus.tx_busy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_wr(1'b1, 8'(8'h10 + i), 1'b0);
      tick();
    end
    bus.tx_busy_i = 1'b0;
    set_wr(1'b1, 8'h55, 1'b0);
    tick();
    chk("pp_count", bus.count_o, 5);
    chk("pp_tx_e", bus.tx_e_o, 1);
    chk("pp_tx_d", bus.tx_d_o, 8'h10);
    set_wr(1'b0, 8'h00, 1'b0);
    go_auto();
    drain(2000);

    // Write while full is rejected even with a pop on the same edge
    auto_tx = 1'b0;
    out_log.delete();
    bus.tx_busy_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_wr(1'b1, 8'(8'hA0 + i), 1'b0);
      tick();
    end
    bus.tx_busy_i = 1'b0;
    set_wr(1'b1, 8'hFF, 1'b0);
    tick();
    chk("fullpop_count", bus.count_o, DEPTH - 1);
    chk("fullpop_ovf", bus.overflow_o, 1);
    chk("fullpop_tx_e", bus.tx_e_o, 1);
    set_wr(1'b0, 8'h00, 1'b1);
    go_auto();
    drain(2000);
    ff_seen = 0;
    foreach (out_log[i]) if (out_log[i] == 8'hFF) ff_seen++;
    chk("fullpop_no_ff", ff_seen, 0);
    chk("fullpop_out_len", out_log.size(), DEPTH);

    // Random stream across several pointer wraps
    out_log.delete();
    in_log.delete();
    tx_len_max = 6;
    accepted = 0;
    n = 0;
    maxc = 0;
    while (accepted < 40 && n < 5000) begin
      v = ($urandom_range(3, 0) != 0);
      d = 8'($urandom);
      set_wr(v, d, 1'b0);
      if (v && mq.size() < DEPTH) begin
        in_log.push_back(d);
        accepted++;
      end
      tick();
      if (int'(bus.count_o) > maxc) maxc = bus.count_o;
      n++;
    end
    chk("rand_timeout", int'(accepted == 40), 1);
    drain(5000);
    chk("rand_count_max", int'(maxc <= DEPTH), 1);
    chk("rand_out_len", out_log.size(), in_log.size());
    for (int i = 0; i < in_log.size() && i < out_log.size(); i++)
      chk($sformatf("rand_out%0d", i), out_log[i], in_log[i]);

    // Reset asserted while waiting on a frame with 3 bytes queued
    auto_tx = 1'b0;
    bus.tx_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_wr(1'b1, 8'(8'hC0 + i), 1'b0);
      tick();
    end
    set_wr(1'b0, 8'h00, 1'b0);
    bus.tx_busy_i = 1'b0;
    tick();
    chk("mid_launch", bus.tx_e_o, 1);
    tick();
    chk("mid_queued", bus.count_o, 3);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_tx_e", bus.tx_e_o, 0);
    chk("mid_rst_count", bus.count_o, 0);
    chk("mid_rst_empty", bus.empty_o, 1);
    chk("mid_rst_tx_d", bus.tx_d_o, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    prev_e = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_no_launch", bus.tx_e_o, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
